// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encodings and values, FSM state encodings, error bit positions.
package vend_pkg;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_20 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CREDIT   = 3'd1,
        S_CHECK    = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4
    } state_e;

    localparam int ERR_ID     = 0;
    localparam int ERR_STOCK  = 1;
    localparam int ERR_CREDIT = 2;

    function automatic logic [5:0] coin_value(input logic [1:0] code);
        logic [5:0] v;
        case (code)
            COIN_5:  v = 6'd5;
            COIN_10: v = 6'd10;
            COIN_20: v = 6'd20;
            default: v = 6'd50;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Combinational greedy change picker: largest coin not exceeding credit; zero latency, no backpressure.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 16
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          chg_code,
    output logic [CREDIT_W-1:0] chg_value
);

    always_comb begin
        chg_code = COIN_5;
        if (credit >= CREDIT_W'(50))
            chg_code = COIN_50;
        else if (credit >= CREDIT_W'(20))
            chg_code = COIN_20;
        else if (credit >= CREDIT_W'(10))
            chg_code = COIN_10;
        chg_value = CREDIT_W'(coin_value(chg_code));
    end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction engine: credit, stock/price tables, multi-qty dispense and greedy change; sel_valid->disp_valid 2 cycles,
// dispense/change outputs hold while their ready is low. Define VEND_DISCOUNT_EN to enable the bulk-quantity discount.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int NUM_PRODUCTS = 8,
    parameter int ID_W         = $clog2(NUM_PRODUCTS),
    parameter int STOCK_W      = 5,
    parameter int INIT_STOCK   = 10,
    parameter int PRICE_W      = 8,
    parameter int QTY_W        = 4,
    parameter int CREDIT_W     = 16,
    parameter int LOW_THRESH   = 5,
    parameter int DISC_QTY     = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                sel_valid,
    input  logic [ID_W-1:0]     sel_id,
    input  logic [QTY_W-1:0]    sel_qty,
    input  logic                cancel,
    input  logic                price_we,
    input  logic [ID_W-1:0]     price_id,
    input  logic [PRICE_W-1:0]  price_data,
    output logic                disp_valid,
    output logic [ID_W-1:0]     disp_id,
    input  logic                disp_ready,
    output logic                chg_valid,
    output logic [1:0]          chg_code,
    input  logic                chg_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock_level,
    output logic                low_stock,
    output logic                coin_reject,
    output logic [2:0]          err,
    output logic [2:0]          state
);

    localparam int COST_W = PRICE_W + QTY_W;
`ifdef VEND_DISCOUNT_EN
    localparam bit DISC_ON = 1'b1;
`else
    localparam bit DISC_ON = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [QTY_W-1:0]    qty_q, qty_d;
    logic [QTY_W-1:0]    remaining_q, remaining_d;
    logic [2:0]          err_q, err_d;
    logic                coin_reject_q, coin_reject_d;
    logic [STOCK_W-1:0]  stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0]  stock_d [NUM_PRODUCTS];
    logic [PRICE_W-1:0]  price_q [NUM_PRODUCTS];
    logic [PRICE_W-1:0]  price_d [NUM_PRODUCTS];

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [COST_W-1:0]   cost_raw, cost;
    logic [COST_W+3:0]   scaled, disc, disc5;
    logic                disc_hit, bad_req;
    logic [1:0]          chg_code_w;
    logic [CREDIT_W-1:0] chg_value_w;

    vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change (
        .credit    (credit_q),
        .chg_code  (chg_code_w),
        .chg_value (chg_value_w)
    );

    // Bulk discount: 90% of cost, floored to a multiple of 5 so credit stays coin-returnable
    always_comb begin
        cost_raw = COST_W'(price_q[id_q]) * COST_W'(qty_q);
        scaled   = (COST_W+4)'(cost_raw) * (COST_W+4)'(9);
        disc     = scaled / (COST_W+4)'(10);
        disc5    = disc - (disc % (COST_W+4)'(5));
        disc_hit = DISC_ON && (32'(qty_q) > DISC_QTY);
        cost     = disc_hit ? COST_W'(disc5) : cost_raw;
        bad_req  = (32'(id_q) >= NUM_PRODUCTS) || (qty_q == '0);
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        id_d          = id_q;
        qty_d         = qty_q;
        remaining_d   = remaining_q;
        err_d         = err_q;
        stock_d       = stock_q;
        price_d       = price_q;
        coin_sum      = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_code));
        coin_ok       = coin_valid && ((state_q == S_IDLE) || (state_q == S_CREDIT)) && !coin_sum[CREDIT_W];
        coin_reject_d = coin_valid && !coin_ok;

        if (sel_valid)
            err_d = '0;

        case (state_q)
            S_IDLE: begin
                if (coin_ok) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    state_d  = S_CREDIT;
                end
                if (price_we && (32'(price_id) < NUM_PRODUCTS))
                    price_d[price_id] = price_data;
            end
            S_CREDIT: begin
                if (coin_ok)
                    credit_d = coin_sum[CREDIT_W-1:0];
                if (cancel) begin
                    state_d = S_CHANGE;
                end else if (sel_valid) begin
                    id_d    = sel_id;
                    qty_d   = sel_qty;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_CREDIT;
                if (bad_req)
                    err_d[ERR_ID] = 1'b1;
                else if (32'(stock_q[id_q]) < 32'(qty_q))
                    err_d[ERR_STOCK] = 1'b1;
                else if (32'(credit_q) < 32'(cost))
                    err_d[ERR_CREDIT] = 1'b1;
                else begin
                    credit_d      = credit_q - CREDIT_W'(cost);
                    stock_d[id_q] = stock_q[id_q] - STOCK_W'(qty_q);
                    remaining_d   = qty_q;
                    state_d       = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                if (disp_ready) begin
                    remaining_d = remaining_q - QTY_W'(1);
                    if (remaining_q == QTY_W'(1))
                        state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else if (chg_ready) begin
                    credit_d = credit_q - chg_value_w;
                    if (credit_d == '0)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            id_q          <= '0;
            qty_q         <= '0;
            remaining_q   <= '0;
            err_q         <= '0;
            coin_reject_q <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
                price_q[i] <= PRICE_W'(5 * (i + 2));
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            id_q          <= id_d;
            qty_q         <= qty_d;
            remaining_q   <= remaining_d;
            err_q         <= err_d;
            coin_reject_q <= coin_reject_d;
            stock_q       <= stock_d;
            price_q       <= price_d;
        end
    end

    always_comb begin
        stock_level = '0;
        if (32'(sel_id) < NUM_PRODUCTS)
            stock_level = stock_q[sel_id];
    end

    assign low_stock   = 32'(stock_level) < LOW_THRESH;
    assign disp_valid  = (state_q == S_DISPENSE);
    assign disp_id     = id_q;
    assign chg_valid   = (state_q == S_CHANGE) && (credit_q != '0);
    assign chg_code    = chg_code_w;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign err         = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: coin table, directed corner sequences, then randomized transactions
// checked against a transaction-level model (credit, stock and price arrays plus greedy change arithmetic).
module tb_vend_txn_controller;
    import vend_pkg::*;

    localparam int NP   = 8;
    localparam int INIT = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        coin_valid = 1'b0;
    logic [1:0]  coin_code = 2'b00;
    logic        sel_valid = 1'b0;
    logic [2:0]  sel_id = 3'd0;
    logic [3:0]  sel_qty = 4'd0;
    logic        cancel = 1'b0;
    logic        price_we = 1'b0;
    logic [2:0]  price_id = 3'd0;
    logic [7:0]  price_data = 8'd0;
    logic        disp_valid;
    logic [2:0]  disp_id;
    logic        disp_ready = 1'b0;
    logic        chg_valid;
    logic [1:0]  chg_code;
    logic        chg_ready = 1'b0;
    logic [15:0] credit;
    logic [4:0]  stock_level;
    logic        low_stock;
    logic        coin_reject;
    logic [2:0]  err;
    logic [2:0]  state;

    always #5 clock = ~clock;

    vend_txn_controller #(.INIT_STOCK(INIT)) dut (
        .clock(clock), .reset(reset),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .sel_id(sel_id), .sel_qty(sel_qty),
        .cancel(cancel),
        .price_we(price_we), .price_id(price_id), .price_data(price_data),
        .disp_valid(disp_valid), .disp_id(disp_id), .disp_ready(disp_ready),
        .chg_valid(chg_valid), .chg_code(chg_code), .chg_ready(chg_ready),
        .credit(credit), .stock_level(stock_level), .low_stock(low_stock),
        .coin_reject(coin_reject), .err(err), .state(state)
    );

    typedef struct {
        logic       cv;
        logic [1:0] code;
        int         exp_credit;
        state_e     exp_state;
        logic       exp_rej;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   m_credit;
    int   m_stock [NP];
    int   m_price [NP];
    int   got_q [$];
    bit   rnd_ready = 1'b0;
    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int val_of(input logic [1:0] c);
        int v;
        case (c)
            2'b00:   v = 5;
            2'b01:   v = 10;
            2'b10:   v = 20;
            default: v = 50;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] code_of(input int v);
        logic [1:0] c;
        case (v)
            5:       c = 2'b00;
            10:      c = 2'b01;
            20:      c = 2'b10;
            default: c = 2'b11;
        endcase
        return c;
    endfunction

    function automatic int greedy(input int c);
        return (c >= 50) ? 50 : (c >= 20) ? 20 : (c >= 10) ? 10 : 5;
    endfunction

    function automatic int model_cost(input int id, input int q);
        int c;
        c = m_price[id] * q;
`ifdef VEND_DISCOUNT_EN
        if (q > 10) begin
            c = (c * 9) / 10;
            c = c - (c % 5);
        end
`endif
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        m_credit = 0;
        for (int i = 0; i < NP; i++) begin
            m_stock[i] = INIT;
            m_price[i] = 5 * (i + 2);
        end
    endtask

    task automatic fund(input int amt);
        int a;
        int v;
        a = amt;
        while (a > 0) begin
            v = greedy(a);
            coin_valid = 1'b1;
            coin_code  = code_of(v);
            tick();
            m_credit += v;
            a -= v;
        end
        coin_valid = 1'b0;
        chk("fund_reject", coin_reject, 0);
        chk("fund_credit", credit, m_credit);
        chk("fund_state", state, S_CREDIT);
    endtask

    task automatic collect_change(input int budget);
        int v;
        got_q.delete();
        for (int n = 0; n < budget && chg_valid; n++) begin
            v = greedy(m_credit);
            chk("chg_code", val_of(chg_code), v);
            chg_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (chg_ready) begin
                got_q.push_back(v);
                m_credit -= v;
            end
            tick();
        end
        chg_ready = 1'b0;
        chk("chg_done", chg_valid, 0);
        chk("chg_credit", credit, m_credit);
    endtask

    task automatic collect_disp(input int id, input int qty, input int stall, input int budget);
        int n;
        n = 0;
        for (int cyc = 0; cyc < budget && disp_valid; cyc++) begin
            chk("disp_id", disp_id, id);
            chk("disp_credit", credit, m_credit);
            chk("disp_stock", stock_level, m_stock[id]);
            if (cyc < stall)
                disp_ready = 1'b0;
            else
                disp_ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (disp_ready)
                n++;
            tick();
        end
        disp_ready = 1'b0;
        chk("disp_count", n, qty);
        chk("disp_done", disp_valid, 0);
    endtask

    task automatic do_sel(input int id, input int qty, input bit with_coin, input int stall);
        int cost;
        int e;
        sel_valid = 1'b1;
        sel_id    = 3'(id);
        sel_qty   = 4'(qty);
        if (with_coin) begin
            coin_valid = 1'b1;
            coin_code  = 2'b01;
        end
        tick();
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        if (with_coin)
            m_credit += 10;
        chk("sel_state", state, S_CHECK);
        chk("sel_disp_early", disp_valid, 0);
        tick();
        cost = model_cost(id, qty);
        e = (qty == 0) ? 1 : (m_stock[id] < qty) ? 2 : (m_credit < cost) ? 4 : 0;
        chk("err", err, e);
        if (e != 0) begin
            chk("fail_state", state, S_CREDIT);
            chk("fail_credit", credit, m_credit);
            chk("fail_stock", stock_level, m_stock[id]);
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            chk("cancel_state", state, S_CHANGE);
        end else begin
            m_credit -= cost;
            m_stock[id] -= qty;
            chk("disp_latency", disp_valid, 1);
            collect_disp(id, qty, stall, 200);
        end
        collect_change(200);
        chk("txn_state", state, S_IDLE);
        chk("txn_credit", credit, 0);
        chk("txn_stock", stock_level, m_stock[id]);
        chk("txn_low", low_stock, int'(m_stock[id] < 5));
    endtask

    task automatic coin1(input int v, input int exp_rej);
        coin_valid = 1'b1;
        coin_code  = code_of(v);
        tick();
        coin_valid = 1'b0;
        if (exp_rej == 0)
            m_credit += v;
        chk("coin_reject", coin_reject, exp_rej);
        chk("coin_credit", credit, m_credit);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 2'b00, 5,  S_CREDIT, 1'b0};
        tbl[1] = '{1'b1, 2'b00, 10, S_CREDIT, 1'b0};
        tbl[2] = '{1'b1, 2'b01, 20, S_CREDIT, 1'b0};
        tbl[3] = '{1'b1, 2'b10, 40, S_CREDIT, 1'b0};
        tbl[4] = '{1'b1, 2'b11, 90, S_CREDIT, 1'b0};
        tbl[5] = '{1'b0, 2'b00, 90, S_CREDIT, 1'b0};

        do_reset();
        sel_id = 3'd1;
        #1;
        chk("rst_credit", credit, 0);
        chk("rst_state", state, S_IDLE);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_chg_valid", chg_valid, 0);
        chk("rst_coin_reject", coin_reject, 0);
        chk("rst_err", err, 0);
        chk("rst_stock", stock_level, INIT);
        chk("rst_low", low_stock, 0);

        for (int i = 0; i < 6; i++) begin
            coin_valid = tbl[i].cv;
            coin_code  = tbl[i].code;
            tick();
            coin_valid = 1'b0;
            chk("tbl_credit", credit, tbl[i].exp_credit);
            chk("tbl_state", state, tbl[i].exp_state);
            chk("tbl_reject", coin_reject, tbl[i].exp_rej);
        end
        m_credit = tbl[5].exp_credit;

        // id1 costs 15: two items out of 90 leave 60, returned as 50 + 10; motor stalls 5 cycles first
        do_sel(1, 2, 1'b0, 5);
        chk("buy_change_n", got_q.size(), 2);
        chk("buy_change_0", got_q[0], 50);
        chk("buy_change_1", got_q[1], 10);
        chk("buy_stock1", stock_level, INIT - 2);

        fund(110);
        do_sel(0, 11, 1'b0, 0);
`ifdef VEND_DISCOUNT_EN
        chk("disc_change_n", got_q.size(), 2);
        chk("disc_change_0", got_q[0], 10);
        chk("disc_change_1", got_q[1], 5);
`else
        chk("nodisc_change_n", got_q.size(), 0);
`endif

        fund(10);
        do_sel(1, 1, 1'b0, 0);
        chk("lowcred_err", err, 4);
        chk("lowcred_change_n", got_q.size(), 1);
        chk("lowcred_change_0", got_q[0], 10);

        fund(10);
        do_sel(2, 0, 1'b0, 0);
        chk("zeroqty_err", err, 1);

        fund(10);
        do_sel(1, 1, 1'b1, 0);
        chk("coinsel_change_n", got_q.size(), 1);
        chk("coinsel_change_0", got_q[0], 5);

        fund(20);
        sel_valid = 1'b1;
        cancel    = 1'b1;
        sel_id    = 3'd1;
        sel_qty   = 4'd1;
        tick();
        sel_valid = 1'b0;
        cancel    = 1'b0;
        chk("cancel_wins_state", state, S_CHANGE);
        collect_change(50);
        chk("cancel_change_n", got_q.size(), 1);
        chk("cancel_change_0", got_q[0], 20);

        price_we   = 1'b1;
        price_id   = 3'd3;
        price_data = 8'd25;
        tick();
        price_we = 1'b0;
        m_price[3] = 25;
        fund(30);
        price_we   = 1'b1;
        price_data = 8'd100;
        tick();
        price_we = 1'b0;
        do_sel(3, 1, 1'b0, 0);
        chk("price_change_0", got_q[0], 5);

        do_reset();
        fund(300);
        do_sel(2, 15, 1'b0, 0);
        chk("stock5_low", low_stock, 0);
        fund(20);
        do_sel(2, 1, 1'b0, 0);
        chk("stock4_level", stock_level, 4);
        chk("stock4_low", low_stock, 1);
        fund(80);
        do_sel(2, 4, 1'b0, 0);
        chk("stock0_level", stock_level, 0);
        fund(20);
        do_sel(2, 1, 1'b0, 0);
        chk("nostock_err", err, 2);

        fund(65500);
        coin1(20, 0);
        coin1(20, 1);
        coin1(10, 0);
        coin1(5, 0);
        coin1(5, 1);
        tick();
        chk("reject_pulse_end", coin_reject, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        coin1(5, 1);
        rnd_ready = 1'b1;
        collect_change(4000);
        chk("ovf_state", state, S_IDLE);

        fund(100);
        cancel = 1'b1;
        tick();
        cancel    = 1'b0;
        chg_ready = 1'b1;
        tick();
        chg_ready = 1'b0;
        chk("midchg_credit", credit, 50);
        reset = 1'b0;
        tick();
        reset  = 1'b1;
        sel_id = 3'd2;
        #1;
        chk("midchg_rst_state", state, S_IDLE);
        chk("midchg_rst_credit", credit, 0);
        chk("midchg_rst_chg", chg_valid, 0);
        chk("midchg_rst_stock", stock_level, INIT);
        do_reset();

        for (int t = 0; t < 40; t++) begin
            int id;
            int qty;
            if ($urandom_range(0, 3) == 0) begin
                id = $urandom_range(0, NP - 1);
                price_we   = 1'b1;
                price_id   = 3'(id);
                price_data = 8'(5 * $urandom_range(1, 20));
                tick();
                price_we = 1'b0;
                m_price[id] = int'(price_data);
            end
            id  = $urandom_range(0, NP - 1);
            qty = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
            fund(5 * $urandom_range(1, 60));
            do_sel(id, qty, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
